// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared packet, byte-count and receive-FSM types for the router.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    typedef struct packed {
        logic [3:0]  srcID;
        logic [3:0]  destID;
        logic [23:0] data;
    } pkt_t;

    localparam int PKT_BYTES = 4;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_B1   = 2'd1,
        RX_B2   = 2'd2,
        RX_B3   = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo
// Description : First-word-fall-through pkt_t queue; head reads as 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         we,
    input  logic                         re,
    input  pkt_t                         data_in,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output pkt_t                         data_out
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    pkt_t                r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    // A write into a full queue is accepted when the head leaves at the same edge.
    assign w_pop  = re & ~empty;
    assign w_push = we & (~full | w_pop);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign data_out = empty ? pkt_t'('0) : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/node_rx_port.sv
`default_nettype none
// ============================================================================
// Module      : node_rx_port
// Description : Node receive port: assembles 4 bytes into a pkt_t and queues it.
// Revision    : 1.0 - initial release
// ============================================================================
module node_rx_port
    import noc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PORTID = 0
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic [7:0]                   payload_in,
    input  logic                         put,
    output logic                         free,
    output logic [31:0]                  pkt_out,
    output logic                         pkt_out_avail,
    input  logic                         req,
    output logic                         drop_err,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int c_cnt_w  = $clog2(DEPTH+1);
    localparam int c_hold_w = (PKT_BYTES-1)*8;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(DEPTH);

    if (DEPTH < 2 || PORTID < 0) begin : g_param_check
        $error("node_rx_port: DEPTH must be >= 2 and PORTID non-negative");
    end

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [c_hold_w-1:0]  r_hold;
    logic                 r_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w:0]     w_slots;
    pkt_t                 w_pkt;
    pkt_t                 w_head;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) r_state <= RX_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (put) begin
            case (r_state)
                RX_IDLE: if (free) w_state_nxt = RX_B1;
                RX_B1:   w_state_nxt = RX_B2;
                RX_B2:   w_state_nxt = RX_B3;
                RX_B3:   w_state_nxt = RX_IDLE;
                default: w_state_nxt = RX_IDLE;
            endcase
        end
    end

    // An in-flight packet holds a slot, so the final-byte write always fits.
    always_comb begin
        w_slots = {1'b0, w_count} + {{c_cnt_w{1'b0}}, (r_state != RX_IDLE)};
        free    = (w_slots < c_depth);
        w_pop   = req & ~w_empty;
        w_push  = (r_state == RX_B3) & put & (~w_full | w_pop);
        w_drop  = (r_state == RX_IDLE) & put & ~free;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_hold <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (put) begin
                case (r_state)
                    RX_IDLE: if (free) r_hold[23:16] <= payload_in;
                    RX_B1:   r_hold[15:8] <= payload_in;
                    RX_B2:   r_hold[7:0]  <= payload_in;
                    default: r_hold <= r_hold;
                endcase
            end
        end
    end

    assign w_pkt = pkt_t'({r_hold, payload_in});

    pkt_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .we       (w_push),
        .re       (w_pop),
        .data_in  (w_pkt),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .data_out (w_head)
    );

    assign pkt_out       = w_head;
    assign pkt_out_avail = ~w_empty;
    assign occupancy     = w_count;
    assign drop_err      = r_drop;

endmodule
`default_nettype wire
